// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - main control FSM for the multicycle RV32I core
//
// Steps lw, sw, R-type, I-type ALU, beq and jal through fetch, decode,
// execute, memory and writeback, driving datapath selects and enables.
//
// Ports:
//   clk         in   rising-edge clock
//   rst_n       in   asynchronous active-low reset
//   op[6:0]     in   opcode from the instruction register
//   zero        in   ALU zero flag
//   mem_ready   in   memory completes the current access this cycle
//   pc_write    out  PC enable (pc_update | branch & zero)
//   adr_src     out  memory address select: 0 = PC, 1 = result
//   mem_write   out  memory write strobe
//   ir_write    out  instruction register / OldPC enable
//   result_src  out  00 = ALUOut, 01 = Data, 10 = ALUResult
//   alu_src_a   out  00 = PC, 01 = OldPC, 10 = rd1
//   alu_src_b   out  00 = rd2, 01 = ImmExt, 10 = constant 4
//   alu_op      out  00 = add, 01 = subtract, 10 = funct-decode
//   imm_src     out  00 = I, 01 = S, 10 = B, 11 = J (decoded from op)
//   reg_write   out  register file write enable
//   illegal_op  out  one-cycle pulse in DECODE for an unsupported opcode
module multicycle_controller (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] imm_src,
  output logic       reg_write,
  output logic       illegal_op
);

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10
  } state_t;

  state_t state, state_next;

  logic pc_update;
  logic branch;
  logic mem_write_s;
  logic ir_write_s;
  logic reg_write_s;
  logic illegal_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_FETCH;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next  = S_FETCH;
    adr_src     = 1'b0;
    mem_write_s = 1'b0;
    ir_write_s  = 1'b0;
    result_src  = 2'b00;
    alu_src_a   = 2'b00;
    alu_src_b   = 2'b00;
    alu_op      = 2'b00;
    reg_write_s = 1'b0;
    illegal_s   = 1'b0;
    pc_update   = 1'b0;
    branch      = 1'b0;

    case (state)
      S_FETCH: begin
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        if (mem_ready) begin
          ir_write_s = 1'b1;
          pc_update  = 1'b1;
          state_next = S_DECODE;
        end else begin
          state_next = S_FETCH;
        end
      end
      S_DECODE: begin
        // ALU precomputes OldPC + imm as the branch target
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (op)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_R:         state_next = S_EXECR;
          OP_I:         state_next = S_EXECI;
          OP_BEQ:       state_next = S_BEQ;
          OP_JAL:       state_next = S_JAL;
          default: begin
            state_next = S_FETCH;
            illegal_s  = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        if (op == OP_SW) begin
          state_next = S_MEMWRITE;
        end else if (op == OP_LW) begin
          state_next = S_MEMREAD;
        end else begin
          state_next = S_FETCH;
        end
      end
      S_MEMREAD: begin
        adr_src    = 1'b1;
        state_next = mem_ready ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        result_src  = 2'b01;
        reg_write_s = 1'b1;
        state_next  = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src     = 1'b1;
        mem_write_s = 1'b1;
        state_next  = mem_ready ? S_FETCH : S_MEMWRITE;
      end
      S_EXECR: begin
        alu_src_a  = 2'b10;
        alu_op     = 2'b10;
        state_next = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a  = 2'b10;
        alu_src_b  = 2'b01;
        alu_op     = 2'b10;
        state_next = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write_s = 1'b1;
        state_next  = S_FETCH;
      end
      S_BEQ: begin
        alu_src_a  = 2'b10;
        alu_op     = 2'b01;
        branch     = 1'b1;
        state_next = S_FETCH;
      end
      S_JAL: begin
        // PC takes the target from ALUOut while the ALU forms OldPC + 4 for rd
        alu_src_a  = 2'b01;
        alu_src_b  = 2'b10;
        pc_update  = 1'b1;
        state_next = S_ALUWB;
      end
      default: begin
        state_next = S_FETCH;
      end
    endcase
  end

  always_comb begin
    case (op)
      OP_SW:   imm_src = 2'b01;
      OP_BEQ:  imm_src = 2'b10;
      OP_JAL:  imm_src = 2'b11;
      default: imm_src = 2'b00;
    endcase
  end

  // Enables are gated by rst_n so a reset mid-instruction kills pending
  // writes combinationally, before the state register has settled.
  assign pc_write   = rst_n & (pc_update | (branch & zero));
  assign ir_write   = rst_n & ir_write_s;
  assign mem_write  = rst_n & mem_write_s;
  assign reg_write  = rst_n & reg_write_s;
  assign illegal_op = rst_n & illegal_s;

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - directed scoreboard bench for multicycle_controller
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] op;
  logic       zero;
  logic       mem_ready;
  logic       pc_write;
  logic       adr_src;
  logic       mem_write;
  logic       ir_write;
  logic [1:0] result_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] imm_src;
  logic       reg_write;
  logic       illegal_op;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [15:0] exp;
    string       tag;
  } sb_entry_t;

  sb_entry_t sb_q[$];

  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] IT  = 7'b0010011;
  localparam logic [6:0] BEQ = 7'b1100011;
  localparam logic [6:0] JAL = 7'b1101111;
  localparam logic [6:0] BAD = 7'b1111111;

  multicycle_controller dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .op         (op),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .pc_write   (pc_write),
    .adr_src    (adr_src),
    .mem_write  (mem_write),
    .ir_write   (ir_write),
    .result_src (result_src),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .imm_src    (imm_src),
    .reg_write  (reg_write),
    .illegal_op (illegal_op)
  );

  always #5 clk = ~clk;

  // Output vector: pc_write, adr_src, mem_write, ir_write, result_src,
  // alu_src_a, alu_src_b, alu_op, imm_src, reg_write, illegal_op
  function automatic logic [15:0] mk(input logic pcw, input logic adr, input logic mw,
                                     input logic irw, input logic [1:0] rs, input logic [1:0] a,
                                     input logic [1:0] b, input logic [1:0] aop,
                                     input logic rw, input logic ill);
    return {pcw, adr, mw, irw, rs, a, b, aop, 2'b00, rw, ill};
  endfunction

  function automatic logic [1:0] imm_of(input logic [6:0] o);
    if (o == SW)  return 2'b01;
    if (o == BEQ) return 2'b10;
    if (o == JAL) return 2'b11;
    return 2'b00;
  endfunction

  logic [15:0] e_fetch_rdy, e_fetch_stall, e_decode, e_decode_ill, e_memadr, e_memread;
  logic [15:0] e_memwb, e_memwrite, e_execr, e_execi, e_aluwb, e_beq_t, e_beq_nt, e_jal;

  function automatic logic [15:0] observed();
    return {pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a, alu_src_b,
            alu_op, imm_src, reg_write, illegal_op};
  endfunction

  task automatic push(input logic [15:0] e, input string tag);
    sb_entry_t ent;
    ent.exp = e | {10'd0, imm_of(op), 2'b00};
    ent.tag = tag;
    sb_q.push_back(ent);
  endtask

  task automatic pop_check();
    sb_entry_t ent;
    logic [15:0] got;
    ent = sb_q.pop_front();
    got = observed();
    n_checks++;
    assert (got === ent.exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", ent.tag, got, ent.exp);
    end
  endtask

  // Called just after a falling edge; ends just after the next falling edge.
  task automatic cyc(input logic [6:0] o, input logic z, input logic r,
                     input logic [15:0] e, input string tag);
    op = o;
    zero = z;
    mem_ready = r;
    push(e, tag);
    #1;
    pop_check();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    e_fetch_rdy   = mk(1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 2'b00, 0, 0);
    e_fetch_stall = mk(0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 0, 0);
    e_decode      = mk(0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, 0, 0);
    e_decode_ill  = mk(0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, 0, 1);
    e_memadr      = mk(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 0, 0);
    e_memread     = mk(0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0);
    e_memwb       = mk(0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 2'b00, 1, 0);
    e_memwrite    = mk(0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0);
    e_execr       = mk(0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10, 0, 0);
    e_execi       = mk(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b10, 0, 0);
    e_aluwb       = mk(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0);
    e_beq_t       = mk(1, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b01, 0, 0);
    e_beq_nt      = mk(0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b01, 0, 0);
    e_jal         = mk(1, 0, 0, 0, 2'b00, 2'b01, 2'b10, 2'b00, 0, 0);

    // Reset with mem_ready high: enables must still be 0, selects at FETCH values
    rst_n = 1'b0;
    op = LW;
    zero = 1'b0;
    mem_ready = 1'b1;
    push(e_fetch_stall, "reset_state");
    #1;
    pop_check();
    @(negedge clk);
    rst_n = 1'b1;

    // lw, no stall, then one MEMREAD stall on a second lw
    cyc(LW, 0, 1, e_fetch_rdy, "lw_fetch");
    cyc(LW, 0, 1, e_decode,    "lw_decode");
    cyc(LW, 0, 0, e_memadr,    "lw_memadr_ignores_ready");
    cyc(LW, 0, 1, e_memread,   "lw_memread");
    cyc(LW, 0, 1, e_memwb,     "lw_memwb");
    cyc(LW, 0, 1, e_fetch_rdy, "lw2_fetch");
    cyc(LW, 0, 1, e_decode,    "lw2_decode");
    cyc(LW, 0, 1, e_memadr,    "lw2_memadr");
    cyc(LW, 0, 0, e_memread,   "lw2_memread_stall");
    cyc(LW, 0, 1, e_memread,   "lw2_memread");
    cyc(LW, 0, 1, e_memwb,     "lw2_memwb");

    // Fetch stall for 3 cycles, then R-type
    for (int i = 0; i < 3; i++) cyc(RT, 0, 0, e_fetch_stall, "fetch_stall");
    cyc(RT, 0, 1, e_fetch_rdy, "rt_fetch");
    cyc(RT, 0, 0, e_decode,    "rt_decode");
    cyc(RT, 1, 0, e_execr,     "rt_execr");
    cyc(RT, 1, 0, e_aluwb,     "rt_aluwb");

    // sw with a 2-cycle write stall
    cyc(SW, 0, 1, e_fetch_rdy, "sw_fetch");
    cyc(SW, 0, 1, e_decode,    "sw_decode");
    cyc(SW, 0, 1, e_memadr,    "sw_memadr");
    cyc(SW, 0, 0, e_memwrite,  "sw_memwrite_stall1");
    cyc(SW, 0, 0, e_memwrite,  "sw_memwrite_stall2");
    cyc(SW, 0, 1, e_memwrite,  "sw_memwrite_done");

    // beq taken and not taken
    cyc(BEQ, 1, 1, e_fetch_rdy, "beq_t_fetch");
    cyc(BEQ, 1, 1, e_decode,    "beq_t_decode");
    cyc(BEQ, 1, 1, e_beq_t,     "beq_taken");
    cyc(BEQ, 0, 1, e_fetch_rdy, "beq_nt_fetch");
    cyc(BEQ, 0, 1, e_decode,    "beq_nt_decode");
    cyc(BEQ, 0, 1, e_beq_nt,    "beq_not_taken");

    // I-type
    cyc(IT, 0, 1, e_fetch_rdy, "it_fetch");
    cyc(IT, 0, 1, e_decode,    "it_decode");
    cyc(IT, 0, 1, e_execi,     "it_execi");
    cyc(IT, 0, 1, e_aluwb,     "it_aluwb");

    // jal
    cyc(JAL, 0, 1, e_fetch_rdy, "jal_fetch");
    cyc(JAL, 0, 1, e_decode,    "jal_decode");
    cyc(JAL, 0, 1, e_jal,       "jal_jal");
    cyc(JAL, 0, 1, e_aluwb,     "jal_aluwb");

    // Illegal opcode returns to FETCH (stalled so no enables at all)
    cyc(BAD, 1, 1, e_fetch_rdy,   "bad_fetch");
    cyc(BAD, 1, 1, e_decode_ill,  "bad_decode");
    cyc(BAD, 1, 0, e_fetch_stall, "bad_back_to_fetch");

    // Reset in the middle of a stalled MEMWRITE
    cyc(SW, 0, 1, e_fetch_rdy, "rst_sw_fetch");
    cyc(SW, 0, 1, e_decode,    "rst_sw_decode");
    cyc(SW, 0, 1, e_memadr,    "rst_sw_memadr");
    mem_ready = 1'b0;
    push(e_memwrite, "rst_sw_memwrite_before");
    #1;
    pop_check();
    #1;
    rst_n = 1'b0;
    push(e_fetch_stall, "rst_sw_memwrite_dropped");
    #1;
    pop_check();
    @(negedge clk);
    rst_n = 1'b1;
    cyc(SW, 0, 0, e_fetch_stall, "after_rst_fetch_stall");
    cyc(SW, 0, 1, e_fetch_rdy,   "after_rst_fetch");
    cyc(SW, 0, 1, e_decode,      "after_rst_decode");

    n_checks++;
    assert (sb_q.size() == 0) else begin
      n_fail++;
      $error("FAIL scoreboard_drain observed=%0d expected=0", sb_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
